upsp_axis_video_out: RTL and testbench
======================================

# upsp_axis_video_out

Downstream output stage of the bicubic upsampling core. Consumes the wide AXI4-Stream produced by the access-control stage (N_PIX pixels per beat) and serialises it into a one-pixel-per-beat AXI4-Stream video interface. The output carries `tuser` as start-of-frame (SOF) and `tlast` as end-of-line (EOL). Tracks the output raster position and checks upstream line framing.

## Interface
Parameters:
- PIXEL_WIDTH, 24: bits per RGB888 pixel.
- N_PIX, 4: pixels per input beat.
- IN_DATA_WIDTH, PIXEL_WIDTH*N_PIX: input tdata width.
- DST_IMG_WIDTH, 3840: output pixels per line; must be a multiple of N_PIX.
- DST_IMG_HEIGHT, 2160: output lines per frame.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tdata  in  IN_DATA_WIDTH  N_PIX pixels; pixel 0 occupies bits [PIXEL_WIDTH-1:0].
- s_axis_tlast  in  1  upstream marks the beat holding the last pixel of a line.
- m_axis_tvalid  out  1  output pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  PIXEL_WIDTH  output pixel.
- m_axis_tuser  out  1  SOF: first pixel of frame.
- m_axis_tlast  out  1  EOL: last pixel of line.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- err_eol  out  1  sticky line-framing mismatch flag.
- err_clr  in  1  synchronous clear of err_eol.

## Operation
- **Hold register.** One IN_DATA_WIDTH hold register with a valid bit `hold_v`, plus a pixel index `idx` in 0..N_PIX-1.
- **Input acceptance.** `s_axis_tready = ~hold_v | (m_axis_tvalid & m_axis_tready & idx==N_PIX-1)`. This allows zero-bubble reload.
- **Beat accept.** On an input accept, the hold register loads tdata, `hold_v` goes to 1, and `idx` goes to 0.
- **Output data.** `m_axis_tvalid = hold_v`. `m_axis_tdata = hold[idx*PIXEL_WIDTH +: PIXEL_WIDTH]`.
- **Pixel accept.** On an output handshake, `idx` increments. At idx==N_PIX-1 it wraps to 0, and `hold_v` clears unless reloaded in the same cycle.
- **Raster counters.** Column counter `col` (0..DST_IMG_WIDTH-1) and row counter `row` (0..DST_IMG_HEIGHT-1) advance per output handshake.
  - `col` wraps to 0 at W-1 and increments `row`.
  - `row` wraps to 0 at H-1.
- **Framing flags.** `m_axis_tuser = (col==0 && row==0)`. `m_axis_tlast = (col==DST_IMG_WIDTH-1)`.
- **End of frame.** On the handshake with row==H-1 and col==W-1, `frame_done` pulses for exactly one cycle on the next clock.
- **Framing check.** On each input accept, expected tlast is computed as "this beat ends at col == W-N_PIX" (the raster position of that beat's pixel 0).
  - If s_axis_tlast differs from the expected value, `err_eol` is set.
  - The counters are never resynchronised; internal counting stays authoritative.
- **err_clr.** Clears `err_eol`. A set and a clear in the same cycle leaves the flag set.
- **Reset values.** All outputs are 0 in reset: s_axis_tready=0, m_axis_tvalid=0, tdata/tuser/tlast=0, frame_done=0, err_eol=0. s_axis_tready rises on the first clock after deassertion. Reset mid-frame discards the held beat and returns col/row to 0.

## Timing
- **Latency.** Input accept at cycle n gives the first pixel valid at cycle n+1.
- **Throughput.** 1 pixel/cycle sustained. The input is accepted 1 cycle in N_PIX when downstream is always ready.
- **Backpressure.** While m_axis_tvalid & ~m_axis_tready, tdata/tuser/tlast hold stable and s_axis_tready=0 whenever `hold_v` is set.
- **Registered logic.** All state is registered. tready, tuser and tlast are combinational from state and m_axis_tready only; there is no s→m combinational path.
- **Counter widths.** `$clog2(DST_IMG_WIDTH)` and `$clog2(DST_IMG_HEIGHT)`. Wrap is by compare, never by overflow.

## Structure
- **Shared package (upsp_pkg):** PIXEL_WIDTH, N_PIX, `pixel_t` typedef, DST_IMG_WIDTH/HEIGHT defaults.
- **Sub-module:** one, `upsp_raster_counter`. It holds col/row with an advance-enable input and outputs sof, eol and eof. The width-serialiser logic stays in the top.

## Test plan
Bench parameters: W=8, H=2, N_PIX=4.
- **Reset mid-stream.** Drive rst_n low during the second line → all outputs 0. The next frame starts with tuser=1 on the first pixel.
- **Continuous stream, downstream ready.** Beats 0x04030201-style pixels → output pixels 1,2,3,4,… in order. tuser only on pixel 0, tlast on pixels 7 and 15, frame_done pulse the cycle after pixel 15; s_axis_tready high 1 cycle in 4.
- **Random m_axis_tready (50%).** Output data and flags stable under stall. The 16-pixel sequence is unchanged and no pixel is lost or duplicated.
- **Framing error.** s_axis_tlast=1 on beat 0 (expected 0) → err_eol=1 next cycle and stays set; output sequence unaffected. err_clr=1 → err_eol=0.
- **Simultaneous error and clear.** Mismatch and err_clr in the same cycle → err_eol=1.
- **Back-to-back frames.** Drive two frames with no gap → second frame pixel 0 carries tuser=1 immediately after frame_done, with no bubble cycle.

Source files
------------

// File: rtl/upsp_pkg.sv
// Shared definitions for the bicubic upsampling output path.
// Holds the default pixel format, the serialiser width and the output
// raster size, plus a helper that sizes a counter for a given range.
package upsp_pkg;

    localparam int PIXEL_WIDTH    = 24;
    localparam int N_PIX          = 4;
    localparam int DST_IMG_WIDTH  = 3840;
    localparam int DST_IMG_HEIGHT = 2160;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    // Bits needed to count 0..n-1; never less than one bit so that a
    // degenerate range still yields a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upsp_raster_counter.sv
// Output raster position tracker.
// Ports:
//   clk, rst_n  core clock, asynchronous active-low reset
//   adv         advance one pixel (output handshake)
//   sof         position is column 0 of row 0
//   eol         position is the last column of a line
//   eof         position is the last column of the last line
module upsp_raster_counter
    import upsp_pkg::*;
#(
    parameter int W = DST_IMG_WIDTH,
    parameter int H = DST_IMG_HEIGHT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adv,
    output logic sof,
    output logic eol,
    output logic eof
);

    localparam int CW = cnt_w(W);
    localparam int RW = cnt_w(H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Wrap by explicit compare so non-power-of-two rasters count correctly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (eol) begin
                col <= '0;
                row <= (row == RW'(H-1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign sof = (col == '0) && (row == '0);
    assign eol = (col == CW'(W-1));
    assign eof = eol && (row == RW'(H-1));

endmodule

// File: rtl/upsp_axis_video_out.sv
// Wide-to-narrow AXI4-Stream video output stage.
// Takes N_PIX pixels per input beat and emits one pixel per beat with
// tuser = start of frame and tlast = end of line. Checks the upstream
// tlast against the locally counted line position.
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   s_axis_*             wide input stream (pixel 0 in the low bits)
//   m_axis_*             one-pixel-per-beat video stream
//   frame_done           one-cycle pulse after the last pixel of a frame
//   err_eol / err_clr    sticky line-framing mismatch flag and its clear
module upsp_axis_video_out #(
    parameter int PIXEL_WIDTH    = upsp_pkg::PIXEL_WIDTH,
    parameter int N_PIX          = upsp_pkg::N_PIX,
    parameter int IN_DATA_WIDTH  = PIXEL_WIDTH*N_PIX,
    parameter int DST_IMG_WIDTH  = upsp_pkg::DST_IMG_WIDTH,
    parameter int DST_IMG_HEIGHT = upsp_pkg::DST_IMG_HEIGHT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [IN_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [PIXEL_WIDTH-1:0]   m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     frame_done,
    output logic                     err_eol,
    input  logic                     err_clr
);

    localparam int IW = upsp_pkg::cnt_w(N_PIX);
    localparam int CW = upsp_pkg::cnt_w(DST_IMG_WIDTH);

    logic [N_PIX-1:0][PIXEL_WIDTH-1:0] hold;
    logic                              hold_v;
    logic [IW-1:0]                     idx;
    logic                              rdy_en;   // keeps tready low through reset and its first clock
    logic [CW-1:0]                     in_col;   // raster column of the next input beat's pixel 0

    logic hs_in, hs_out, last_px, exp_last;
    logic sof, eol, eof;

    assign last_px = (idx == IW'(N_PIX-1));
    assign hs_out  = hold_v & m_axis_tready;

    // Reload is allowed in the same cycle the final held pixel leaves.
    assign s_axis_tready = rdy_en & (~hold_v | (hs_out & last_px));
    assign hs_in         = s_axis_tvalid & s_axis_tready;

    assign m_axis_tvalid = hold_v;
    assign m_axis_tdata  = hold[idx];
    // Flags are qualified by valid so they read 0 while idle / in reset.
    assign m_axis_tuser  = hold_v & sof;
    assign m_axis_tlast  = hold_v & eol;

    // An input beat is line-final when its first pixel lands at W-N_PIX.
    // Tracked on the input side so reloads during the last output pixel
    // of the previous beat need no look-ahead on the output counters.
    assign exp_last = (in_col == CW'(DST_IMG_WIDTH-N_PIX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            hold_v     <= 1'b0;
            idx        <= '0;
            rdy_en     <= 1'b0;
            in_col     <= '0;
            frame_done <= 1'b0;
            err_eol    <= 1'b0;
        end else begin
            rdy_en     <= 1'b1;
            frame_done <= hs_out & eof;

            if (hs_in) begin
                hold   <= s_axis_tdata;
                hold_v <= 1'b1;
                idx    <= '0;
                in_col <= exp_last ? '0 : in_col + CW'(N_PIX);
            end else if (hs_out) begin
                if (last_px) begin
                    idx    <= '0;
                    hold_v <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            // Set wins over clear; counters are never resynchronised.
            if (hs_in && (s_axis_tlast != exp_last))
                err_eol <= 1'b1;
            else if (err_clr)
                err_eol <= 1'b0;
        end
    end

    upsp_raster_counter #(
        .W (DST_IMG_WIDTH),
        .H (DST_IMG_HEIGHT)
    ) u_raster (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (hs_out),
        .sof   (sof),
        .eol   (eol),
        .eof   (eof)
    );

endmodule

// File: tb/tb_upsp_axis_video_out.sv
// Bench for upsp_axis_video_out with an 8x2 raster and 4 pixels per beat.
module tb_upsp_axis_video_out;

    localparam int PW = 24;
    localparam int NP = 4;
    localparam int W  = 8;
    localparam int H  = 2;
    localparam int FP = W*H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [PW*NP-1:0] s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [PW-1:0] m_tdata;
    logic          m_tuser, m_tlast;
    logic          frame_done, err_eol;
    logic          err_clr = 1'b0;

    int  vectors = 0;
    int  errors  = 0;
    bit  rand_rdy = 1'b0;

    // model state
    logic [PW-1:0] q[$];
    int  k = 0;          // output pixels since reset
    int  bin = 0;        // input beats since reset
    bit  err_m = 0, fd_m = 0, rdy_ok = 0;
    int  fd_cnt = 0, tuser_cnt = 0, tlast_cnt = 0, vcyc = 0;
    bit  prev_stall = 0;
    logic [PW-1:0] prev_data;
    logic prev_user, prev_last;

    upsp_axis_video_out #(
        .PIXEL_WIDTH    (PW),
        .N_PIX          (NP),
        .IN_DATA_WIDTH  (PW*NP),
        .DST_IMG_WIDTH  (W),
        .DST_IMG_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .frame_done    (frame_done),
        .err_eol       (err_eol),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always ready or a 50% coin, changed just after each edge.
    always @(posedge clk) begin
        #1;
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference model and per-cycle compare.
    always @(negedge clk) begin
        bit hs_in, hs_out, mism;
        if (!rst_n) begin
            chk("rst_outputs", {s_tready, m_tvalid, m_tuser, m_tlast, frame_done, err_eol}, 32'd0);
            chk("rst_tdata", m_tdata, 32'd0);
            q.delete();
            k = 0; bin = 0; err_m = 0; fd_m = 0; rdy_ok = 0; prev_stall = 0;
        end else begin
            chk("s_tready", s_tready,
                rdy_ok && (q.size() == 0 || (q.size() == 1 && m_tready)));
            chk("m_tvalid", m_tvalid, q.size() != 0);
            if (q.size() != 0) begin
                chk("m_tdata", m_tdata, q[0]);
                chk("m_tuser", m_tuser, (k % FP) == 0);
                chk("m_tlast", m_tlast, (k % W) == W-1);
            end else begin
                chk("idle_flags", {m_tuser, m_tlast}, 32'd0);
            end
            if (prev_stall)
                chk("stall_stable", {m_tvalid, m_tuser, m_tlast, m_tdata},
                    {1'b1, prev_user, prev_last, prev_data});
            chk("frame_done", frame_done, fd_m);
            chk("err_eol", err_eol, err_m);

            // events at the coming edge
            hs_in  = s_tvalid && s_tready;
            hs_out = m_tvalid && m_tready;
            prev_stall = m_tvalid && !m_tready;
            prev_data = m_tdata; prev_user = m_tuser; prev_last = m_tlast;
            if (frame_done) fd_cnt++;
            if (m_tvalid) vcyc++;
            fd_m = hs_out && ((k % FP) == FP-1);
            if (hs_out) begin
                if (m_tuser) tuser_cnt++;
                if (m_tlast) tlast_cnt++;
                if (q.size() != 0) void'(q.pop_front());
                k++;
            end
            if (hs_in) begin
                for (int i = 0; i < NP; i++) q.push_back(s_tdata[i*PW +: PW]);
                mism = (s_tlast != ((bin % (W/NP)) == (W/NP) - 1));
                bin++;
            end else begin
                mism = 0;
            end
            if (hs_in && mism) err_m = 1;
            else if (err_clr)  err_m = 0;
            rdy_ok = 1;
        end
    end

    function automatic logic [PW*NP-1:0] mk(input int tag, input int b);
        logic [PW*NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i*PW +: PW] = PW'(tag*4096 + b*NP + i + 1);
        return r;
    endfunction

    task automatic send_beat(input logic [PW*NP-1:0] d, input bit l, input bit clr);
        bit acc;
        int n;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l; err_clr = clr;
        n = 0; acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_tready;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; err_clr = 1'b0;
    endtask

    // bad / clr select a beat index (-1 for none)
    task automatic send_frame(input int tag, input int bad, input int clr);
        for (int b = 0; b < FP/NP; b++)
            send_beat(mk(tag, b), ((b % (W/NP)) == (W/NP) - 1) ^ (b == bad), b == clr);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (!m_tvalid && !s_tvalid) break;
            n++;
        end
        if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int bubbles;
        // reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("tready_first_cycle", s_tready, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // continuous stream, downstream always ready
        vcyc = 0;
        send_frame(0, -1, -1);
        wait_drain();
        chk("A_pixels", k, 32'd16);
        chk("A_valid_cycles", vcyc, 32'd16);
        chk("A_frame_done", fd_cnt, 32'd1);
        chk("A_tuser_cnt", tuser_cnt, 32'd1);
        chk("A_tlast_cnt", tlast_cnt, 32'd2);

        // random downstream ready
        @(posedge clk); #1;
        rand_rdy = 1'b1;
        send_frame(1, -1, -1);
        wait_drain();
        rand_rdy = 1'b0;
        chk("B_pixels", k, 32'd32);
        chk("B_frame_done", fd_cnt, 32'd2);

        // framing error on beat 0, then clear
        @(posedge clk); #1;
        send_frame(2, 0, -1);
        wait_drain();
        chk("C_err_set", err_eol, 32'd1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("C_err_clr", err_eol, 32'd0);

        // mismatch and clear on the same beat
        @(posedge clk); #1;
        send_frame(3, 2, 2);
        wait_drain();
        chk("D_set_wins", err_eol, 32'd1);
        chk("D_frame_done", fd_cnt, 32'd4);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;

        // back-to-back frames, no bubble
        bubbles = 0;
        fork
            begin
                send_frame(4, -1, -1);
                send_frame(5, -1, -1);
            end
            begin
                int n = 0;
                while (!m_tvalid && n < 50) begin @(negedge clk); n++; end
                if (n >= 50) chk("E_start_timeout", 32'd0, 32'd1);
                for (int i = 0; i < 2*FP - 1; i++) begin
                    @(negedge clk);
                    if (!m_tvalid) bubbles++;
                end
            end
        join
        wait_drain();
        chk("E_bubbles", bubbles, 32'd0);
        chk("E_frame_done", fd_cnt, 32'd6);
        chk("E_tuser_cnt", tuser_cnt, 32'd6);

        // reset in the middle of the second line
        @(posedge clk); #1;
        send_beat(mk(6, 0), 1'b0, 1'b0);
        send_beat(mk(6, 1), 1'b1, 1'b0);
        send_beat(mk(6, 2), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("R_valid_low", m_tvalid, 32'd0);
        chk("R_ready_low", s_tready, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        send_frame(7, -1, -1);
        wait_drain();
        chk("R_pixels", k, 32'd16);
        chk("R_frame_done", fd_cnt, 32'd7);
        chk("R_err_clean", err_eol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
